elevator_dispatcher: RTL and testbench

- Central hall-call scheduler that shares two elevator cars between N_FLOORS call buttons.
- Latches floor calls into a pending set and picks the next floor with round-robin fairness.
- Assigns each picked floor to the nearest idle car and hands it over on a per-car valid/ready handshake.
- Sits between the floor call panel and the two car motion controllers, which execute one target floor at a time.

---
 rtl/elevator_pkg.sv | 32 +++
 rtl/rr_floor_picker.sv | 30 +++
 rtl/elevator_dispatcher.sv | 136 +++++++++++++
 tb/tb_elevator_dispatcher.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator dispatcher.
//   N_FLOORS : number of floors, numbered 1..N_FLOORS (pending bit i = floor i+1)
//   FLOOR_W  : width of a floor number; NO_FLOOR (0) means "no floor"
//   IDX_W    : width of a pending-bit index
//   state_t  : dispatcher FSM state, with constants IDLE / PICK / OFFER
package elevator_pkg;

  localparam int unsigned N_FLOORS = 8;
  localparam int unsigned FLOOR_W  = 4;
  localparam int unsigned IDX_W    = $clog2(N_FLOORS);

  typedef logic [FLOOR_W-1:0] floor_t;
  typedef logic [IDX_W-1:0]   idx_t;

  localparam floor_t NO_FLOOR = '0;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t PICK  = 2'd1;
  localparam state_t OFFER = 2'd2;

  // Unsigned absolute distance between two floors.
  function automatic floor_t floor_dist(floor_t a, floor_t b);
    return (a >= b) ? floor_t'(a - b) : floor_t'(b - a);
  endfunction

  // Pending-bit index to 1-based floor number.
  function automatic floor_t idx_to_floor(idx_t i);
    return floor_t'(floor_t'(i) + floor_t'(1));
  endfunction

endpackage

// File: rtl/rr_floor_picker.sv
// Combinational round-robin priority encoder over the pending-call set.
//   pending : candidate floors, bit i = floor i+1
//   rr_ptr  : index where the upward search starts (wraps past N_FLOORS-1 to 0)
//   found   : at least one bit of pending is set
//   index   : first set bit at or after rr_ptr; 0 when found is low
module rr_floor_picker
  import elevator_pkg::*;
(
  input  logic [N_FLOORS-1:0] pending,
  input  logic [IDX_W-1:0]    rr_ptr,
  output logic                found,
  output logic [IDX_W-1:0]    index
);

  always_comb begin
    int unsigned pos;
    found = 1'b0;
    index = '0;
    pos   = 0;
    // Walk offsets from farthest to nearest so the nearest hit is written last.
    for (int unsigned off = N_FLOORS; off > 0; off--) begin
      pos = (32'(rr_ptr) + off - 1) % N_FLOORS;
      if (pending[idx_t'(pos)]) begin
        found = 1'b1;
        index = idx_t'(pos);
      end
    end
  end

endmodule

// File: rtl/elevator_dispatcher.sv
// Hall-call scheduler sharing two cars between N_FLOORS call buttons.
// Calls are latched into a pending set; one floor at a time is picked round-robin,
// assigned to the nearest idle car and offered on that car's valid/ready handshake.
//   CLK, RST_N                   : clock (rising edge), async active-low reset
//   call_req / cancel_req        : per-floor call set / withdraw (cancel wins)
//   car1_floor / car2_floor      : current car positions (1..N_FLOORS)
//   car1_idle / car2_idle        : car can accept a new target
//   dispatch_valid1/2, _floor1/2 : target offer per car (floor 0 when not valid)
//   dispatch_ready1/2            : car accepts the offer
//   pending                      : registered pending-call set
//   busy                         : FSM is in PICK or OFFER
module elevator_dispatcher
  import elevator_pkg::*;
(
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [N_FLOORS-1:0] call_req,
  input  logic [N_FLOORS-1:0] cancel_req,
  input  logic [FLOOR_W-1:0]  car1_floor,
  input  logic [FLOOR_W-1:0]  car2_floor,
  input  logic                car1_idle,
  input  logic                car2_idle,
  output logic                dispatch_valid1,
  output logic [FLOOR_W-1:0]  dispatch_floor1,
  input  logic                dispatch_ready1,
  output logic                dispatch_valid2,
  output logic [FLOOR_W-1:0]  dispatch_floor2,
  input  logic                dispatch_ready2,
  output logic [N_FLOORS-1:0] pending,
  output logic                busy
);

  state_t              state_q, state_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  idx_t                rr_ptr_q, rr_ptr_d;
  idx_t                target_q, target_d;
  logic                car_sel_q, car_sel_d;  // 0 = car 1, 1 = car 2

  logic [N_FLOORS-1:0] pick_set;
  logic                pick_found;
  idx_t                pick_idx;
  floor_t              pick_floor;
  floor_t              dist1, dist2;
  logic                pick_car2;
  logic                any_idle;

  floor_t              offer_floor;
  logic                offering;
  logic                handshake;
  logic                cancel_hit;
  logic [N_FLOORS-1:0] accepted;

  // A floor cancelled in the PICK cycle must not be chosen.
  assign pick_set = pending_q & ~cancel_req;

  rr_floor_picker u_picker (
    .pending (pick_set),
    .rr_ptr  (rr_ptr_q),
    .found   (pick_found),
    .index   (pick_idx)
  );

  assign pick_floor = idx_to_floor(pick_idx);
  assign dist1      = floor_dist(car1_floor, pick_floor);
  assign dist2      = floor_dist(car2_floor, pick_floor);
  assign any_idle   = car1_idle | car2_idle;
  // Car 2 only when it is strictly closer or car 1 is not available; ties go to car 1.
  assign pick_car2  = car2_idle & (~car1_idle | (dist2 < dist1));

  assign offering    = (state_q == OFFER);
  assign offer_floor = idx_to_floor(target_q);
  assign handshake   = offering & (car_sel_q ? dispatch_ready2 : dispatch_ready1);
  assign cancel_hit  = offering & cancel_req[target_q];
  assign accepted    = handshake ? (N_FLOORS'(1) << target_q) : '0;

  // Accepted floor also absorbs a same-cycle call for that floor.
  assign pending_d = (pending_q | call_req) & ~cancel_req & ~accepted;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    target_d  = target_q;
    car_sel_d = car_sel_q;
    unique case (state_q)
      IDLE: begin
        if ((pending_q != '0) && any_idle) begin
          state_d = PICK;
        end
      end
      PICK: begin
        if (!any_idle || !pick_found) begin
          state_d = IDLE;
        end else begin
          target_d  = pick_idx;
          car_sel_d = pick_car2;
          state_d   = OFFER;
        end
      end
      OFFER: begin
        // Ready wins over a simultaneous cancel.
        if (handshake) begin
          rr_ptr_d = idx_t'((32'(target_q) + 1) % N_FLOORS);
          state_d  = IDLE;
        end else if (cancel_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      pending_q <= '0;
      rr_ptr_q  <= '0;
      target_q  <= '0;
      car_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      target_q  <= target_d;
      car_sel_q <= car_sel_d;
    end
  end

  // Outputs decode from registered state only, so an async reset clears them at once.
  assign dispatch_valid1 = offering & ~car_sel_q;
  assign dispatch_valid2 = offering & car_sel_q;
  assign dispatch_floor1 = dispatch_valid1 ? offer_floor : NO_FLOOR;
  assign dispatch_floor2 = dispatch_valid2 ? offer_floor : NO_FLOOR;
  assign pending         = pending_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Self-checking bench for elevator_dispatcher: scenario tasks with inline checks plus a
// dispatch scoreboard (expected {car, floor} pushed when calls are driven, compared
// against handshakes observed on the DUT ports).
module tb_elevator_dispatcher;
  import elevator_pkg::*;

  logic                CLK = 1'b0;
  logic                RST_N = 1'b0;
  logic [N_FLOORS-1:0] call_req = '0;
  logic [N_FLOORS-1:0] cancel_req = '0;
  logic [FLOOR_W-1:0]  car1_floor = 4'd1;
  logic [FLOOR_W-1:0]  car2_floor = 4'd8;
  logic                car1_idle = 1'b1;
  logic                car2_idle = 1'b1;
  logic                dispatch_valid1, dispatch_valid2;
  logic [FLOOR_W-1:0]  dispatch_floor1, dispatch_floor2;
  logic                dispatch_ready1 = 1'b0;
  logic                dispatch_ready2 = 1'b0;
  logic [N_FLOORS-1:0] pending;
  logic                busy;

  typedef struct {
    int car;
    int floor;
  } disp_t;

  disp_t exp_q[$];
  disp_t obs_q[$];
  int    checks = 0;
  int    failures = 0;
  bit    both_high = 1'b0;

  elevator_dispatcher dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .call_req        (call_req),
    .cancel_req      (cancel_req),
    .car1_floor      (car1_floor),
    .car2_floor      (car2_floor),
    .car1_idle       (car1_idle),
    .car2_idle       (car2_idle),
    .dispatch_valid1 (dispatch_valid1),
    .dispatch_floor1 (dispatch_floor1),
    .dispatch_ready1 (dispatch_ready1),
    .dispatch_valid2 (dispatch_valid2),
    .dispatch_floor2 (dispatch_floor2),
    .dispatch_ready2 (dispatch_ready2),
    .pending         (pending),
    .busy            (busy)
  );

  always #5 CLK = ~CLK;

  // Record every completed handshake and any cycle with both valids high.
  always @(posedge CLK) begin
    disp_t d;
    if (dispatch_valid1 && dispatch_valid2) both_high <= 1'b1;
    if (RST_N && dispatch_valid1 && dispatch_ready1) begin
      d.car = 1; d.floor = int'(dispatch_floor1); obs_q.push_back(d);
    end
    if (RST_N && dispatch_valid2 && dispatch_ready2) begin
      d.car = 2; d.floor = int'(dispatch_floor2); obs_q.push_back(d);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input int car, input int floor);
    disp_t d;
    d.car = car; d.floor = floor;
    exp_q.push_back(d);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    call_req = '0; cancel_req = '0;
    dispatch_ready1 = 1'b0; dispatch_ready2 = 1'b0;
    car1_idle = 1'b1; car2_idle = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    step();
  endtask

  // Handshake whichever offer appears first; an expired bound counts as a failure.
  task automatic accept_next(input int max_cycles);
    bit got = 1'b0;
    for (int i = 0; i < max_cycles && !got; i++) begin
      if (dispatch_valid1) begin dispatch_ready1 = 1'b1; got = 1'b1; end
      else if (dispatch_valid2) begin dispatch_ready2 = 1'b1; got = 1'b1; end
      step();
    end
    dispatch_ready1 = 1'b0; dispatch_ready2 = 1'b0;
    checks++;
    if (got !== 1'b1) begin
      failures++;
      $display("FAIL accept_next: no offer within %0d cycles (got %0b, need 1)", max_cycles, got);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pending !== '0) begin failures++;
      $display("FAIL reset_pending: got %0h need 0", pending); end
    checks++; if (busy !== 1'b0) begin failures++;
      $display("FAIL reset_busy: got %0b need 0", busy); end
    checks++; if ({dispatch_valid1, dispatch_valid2} !== 2'b00) begin failures++;
      $display("FAIL reset_valid: got %b need 00", {dispatch_valid1, dispatch_valid2}); end
    checks++; if ({dispatch_floor1, dispatch_floor2} !== 8'h00) begin failures++;
      $display("FAIL reset_floor: got %h need 00", {dispatch_floor1, dispatch_floor2}); end
  endtask

  task automatic test_nearest();
    do_reset();
    car1_floor = 4'd1; car2_floor = 4'd6;
    call_req = 8'h10;
    step(); call_req = '0;
    checks++; if (pending !== 8'h10) begin failures++;
      $display("FAIL nearest_pending: got %h need 10", pending); end
    checks++; if (busy !== 1'b0) begin failures++;
      $display("FAIL nearest_idle_busy: got %0b need 0", busy); end
    step();
    checks++; if (busy !== 1'b1 || dispatch_valid2 !== 1'b0) begin failures++;
      $display("FAIL nearest_pick: busy=%0b valid2=%0b need 1/0", busy, dispatch_valid2); end
    step();
    checks++; if (dispatch_valid2 !== 1'b1 || dispatch_floor2 !== 4'd5) begin failures++;
      $display("FAIL nearest_offer: valid2=%0b floor2=%0d need 1/5",
               dispatch_valid2, dispatch_floor2); end
    checks++; if (dispatch_valid1 !== 1'b0 || dispatch_floor1 !== 4'd0) begin failures++;
      $display("FAIL nearest_car1_quiet: valid1=%0b floor1=%0d need 0/0",
               dispatch_valid1, dispatch_floor1); end
    push_exp(2, 5);
    dispatch_ready2 = 1'b1;
    step(); dispatch_ready2 = 1'b0;
    checks++; if (pending !== '0 || dispatch_valid2 !== 1'b0) begin failures++;
      $display("FAIL nearest_done: pending=%h valid2=%0b need 00/0", pending, dispatch_valid2); end
  endtask

  task automatic test_tie();
    car1_floor = 4'd2; car2_floor = 4'd4;
    call_req = 8'h04;
    step(); call_req = '0;
    step(2);
    checks++; if (dispatch_valid1 !== 1'b1 || dispatch_floor1 !== 4'd3) begin failures++;
      $display("FAIL tie_offer: valid1=%0b floor1=%0d need 1/3", dispatch_valid1, dispatch_floor1);
    end
    checks++; if (dispatch_valid2 !== 1'b0) begin failures++;
      $display("FAIL tie_car2: valid2=%0b need 0", dispatch_valid2); end
    push_exp(1, 3);
    // Same-floor call during the handshake must be absorbed.
    dispatch_ready1 = 1'b1; call_req = 8'h04;
    step(); dispatch_ready1 = 1'b0; call_req = '0;
    checks++; if (pending !== '0 || dispatch_valid1 !== 1'b0) begin failures++;
      $display("FAIL tie_absorb: pending=%h valid1=%0b need 00/0", pending, dispatch_valid1); end
  endtask

  task automatic test_round_robin();
    do_reset();
    car1_floor = 4'd1; car2_floor = 4'd8;
    push_exp(1, 2); push_exp(2, 7);
    call_req = 8'h42;
    step(); call_req = '0;
    accept_next(6);
    checks++; if (pending !== 8'h40) begin failures++;
      $display("FAIL rr_after_first: pending=%h need 40", pending); end
    push_exp(1, 2);
    call_req = 8'h02;
    step(); call_req = '0;
    accept_next(6);
    accept_next(6);
    checks++; if (pending !== '0) begin failures++;
      $display("FAIL rr_drained: pending=%h need 00", pending); end
  endtask

  task automatic test_cancel_offer();
    int n_obs;
    do_reset();
    car1_floor = 4'd1; car2_floor = 4'd8;
    call_req = 8'h08;
    step(); call_req = '0;
    step(2);
    checks++; if (dispatch_valid1 !== 1'b1 || dispatch_floor1 !== 4'd4) begin failures++;
      $display("FAIL cancel_offer: valid1=%0b floor1=%0d need 1/4",
               dispatch_valid1, dispatch_floor1); end
    step();
    checks++; if (dispatch_valid1 !== 1'b1 || dispatch_floor1 !== 4'd4) begin failures++;
      $display("FAIL cancel_hold: valid1=%0b floor1=%0d need 1/4",
               dispatch_valid1, dispatch_floor1); end
    n_obs = obs_q.size();
    cancel_req = 8'h08;
    step(); cancel_req = '0;
    checks++; if (dispatch_valid1 !== 1'b0 || pending !== '0 || busy !== 1'b0) begin failures++;
      $display("FAIL cancel_drop: valid1=%0b pending=%h busy=%0b need 0/00/0",
               dispatch_valid1, pending, busy); end
    checks++; if (obs_q.size() !== n_obs) begin failures++;
      $display("FAIL cancel_no_hs: handshakes=%0d need %0d", obs_q.size(), n_obs); end
    // rr_ptr still 0: floor 2 must come before floor 8.
    push_exp(1, 2); push_exp(2, 8);
    call_req = 8'h82;
    step(); call_req = '0;
    accept_next(6);
    accept_next(6);
  endtask

  task automatic test_cancel_ready();
    car1_floor = 4'd1; car2_floor = 4'd8;
    call_req = 8'h10;
    step(); call_req = '0;
    step(2);
    checks++; if (dispatch_valid2 !== 1'b1 || dispatch_floor2 !== 4'd5) begin failures++;
      $display("FAIL cr_offer: valid2=%0b floor2=%0d need 1/5", dispatch_valid2, dispatch_floor2);
    end
    push_exp(2, 5);
    dispatch_ready2 = 1'b1; cancel_req = 8'h10;
    step(); dispatch_ready2 = 1'b0; cancel_req = '0;
    checks++; if (pending !== '0 || dispatch_valid2 !== 1'b0) begin failures++;
      $display("FAIL cr_done: pending=%h valid2=%0b need 00/0", pending, dispatch_valid2); end
    // rr_ptr now 5: floor 7 before floor 1.
    push_exp(2, 7); push_exp(1, 1);
    call_req = 8'h41;
    step(); call_req = '0;
    accept_next(6);
    accept_next(6);
  endtask

  task automatic test_no_idle();
    do_reset();
    car1_floor = 4'd1; car2_floor = 4'd8;
    car1_idle = 1'b0; car2_idle = 1'b0;
    call_req = 8'h14;
    step(); call_req = '0;
    step(3);
    checks++; if (busy !== 1'b0 || {dispatch_valid1, dispatch_valid2} !== 2'b00) begin
      failures++;
      $display("FAIL noidle_wait: busy=%0b valids=%b need 0/00",
               busy, {dispatch_valid1, dispatch_valid2}); end
    checks++; if (pending !== 8'h14) begin failures++;
      $display("FAIL noidle_pending: got %h need 14", pending); end
    car2_idle = 1'b1;
    step(2);
    checks++; if (dispatch_valid2 !== 1'b1 || dispatch_floor2 !== 4'd3 ||
                  dispatch_valid1 !== 1'b0) begin failures++;
      $display("FAIL noidle_offer: valid2=%0b floor2=%0d valid1=%0b need 1/3/0",
               dispatch_valid2, dispatch_floor2, dispatch_valid1); end
    push_exp(2, 3);
    accept_next(4);
    push_exp(2, 5);
    accept_next(6);
    car1_idle = 1'b1;
  endtask

  task automatic test_reset_mid_offer();
    do_reset();
    car1_floor = 4'd6; car2_floor = 4'd8;
    call_req = 8'h20;
    step(); call_req = '0;
    step(2);
    checks++; if (dispatch_valid1 !== 1'b1 || dispatch_floor1 !== 4'd6) begin failures++;
      $display("FAIL rst_pre_offer: valid1=%0b floor1=%0d need 1/6",
               dispatch_valid1, dispatch_floor1); end
    #2 RST_N = 1'b0;
    #1;
    checks++; if (dispatch_valid1 !== 1'b0 || dispatch_floor1 !== 4'd0 || busy !== 1'b0 ||
                  pending !== '0) begin failures++;
      $display("FAIL rst_async: valid1=%0b floor1=%0d busy=%0b pending=%h need 0/0/0/00",
               dispatch_valid1, dispatch_floor1, busy, pending); end
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || pending !== '0 || dispatch_valid1 !== 1'b0) begin failures++;
      $display("FAIL rst_release: busy=%0b pending=%h valid1=%0b need 0/00/0",
               busy, pending, dispatch_valid1); end
  endtask

  task automatic test_scoreboard();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size()) begin
        failures++;
        $display("FAIL sb_missing[%0d]: got none need car%0d floor%0d",
                 i, exp_q[i].car, exp_q[i].floor);
      end else if (obs_q[i].car !== exp_q[i].car || obs_q[i].floor !== exp_q[i].floor) begin
        failures++;
        $display("FAIL sb_dispatch[%0d]: got car%0d floor%0d need car%0d floor%0d", i,
                 obs_q[i].car, obs_q[i].floor, exp_q[i].car, exp_q[i].floor);
      end
    end
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++;
      $display("FAIL sb_count: got %0d handshakes need %0d", obs_q.size(), exp_q.size()); end
    checks++; if (both_high !== 1'b0) begin failures++;
      $display("FAIL both_valid: got %0b need 0", both_high); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nearest();
    test_tie();
    test_round_robin();
    test_cancel_offer();
    test_cancel_ready();
    test_no_idle();
    test_reset_mid_offer();
    test_scoreboard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
